// File: rtl/axis_fifo_pkg.sv
// Shared types and the round-robin selection helper for the AXIS FIFO write arbiter.
package axis_fifo_pkg;

  localparam int unsigned RR_MAX_PORTS = 16;
  localparam int unsigned RR_IDX_W     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Returns {found, winner}: first eligible port searching upward from last_grant+1, wrapping.
  function automatic logic [RR_IDX_W:0] rr_pick(input logic [RR_MAX_PORTS-1:0] eligible,
                                                input logic [RR_IDX_W-1:0]     last_grant,
                                                input int unsigned             num_ports);
    logic                found;
    logic [RR_IDX_W-1:0] win;
    int unsigned         idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned off = 1; off <= RR_MAX_PORTS; off++) begin
      if (off <= num_ports) begin
        idx = (32'(last_grant) + off) % num_ports;
        if (!found && eligible[RR_IDX_W'(idx)]) begin
          found = 1'b1;
          win   = RR_IDX_W'(idx);
        end
      end
    end
    return {found, win};
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin priority selector over NUM_PORTS requesters.
module axis_rr_pick
  import axis_fifo_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [IDX_WIDTH-1:0] last_grant,
  output logic [IDX_WIDTH-1:0] winner_c,
  output logic                 found_c
);

  logic [RR_IDX_W:0] pick;

  always_comb begin
    pick     = rr_pick(RR_MAX_PORTS'(eligible), RR_IDX_W'(last_grant), NUM_PORTS);
    winner_c = IDX_WIDTH'(pick[RR_IDX_W-1:0]);
    found_c  = pick[RR_IDX_W];
  end

endmodule

// File: rtl/axis_fifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing the AXIS async FIFO write port among NUM_PORTS requesters.
module axis_fifo_wr_arbiter
  import axis_fifo_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_req_tdata,
  input  logic [NUM_PORTS*STRB_WIDTH-1:0] s_req_tstrb,
  input  logic [NUM_PORTS-1:0]            s_req_tlast,
  input  logic [NUM_PORTS-1:0]            s_req_tvalid,
  output logic [NUM_PORTS-1:0]            s_req_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [STRB_WIDTH-1:0]           m_axis_tstrb,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  input  logic                            fifo_almost_full,
  input  logic                            cfg_enable,
  input  logic [NUM_PORTS-1:0]            cfg_port_mask,
  output logic                            grant_active,
  output logic [IDX_WIDTH-1:0]            grant_idx,
  output logic                            pkt_done
);

  arb_state_t             state_q, state_d;
  logic [IDX_WIDTH-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic                   pkt_done_q, pkt_done_d;
  logic                   af_q;

  logic [NUM_PORTS-1:0]   eligible;
  logic [IDX_WIDTH-1:0]   winner_c;
  logic                   found_c;

  logic [DATA_WIDTH-1:0]  req_data [NUM_PORTS];
  logic [STRB_WIDTH-1:0]  req_strb [NUM_PORTS];

  assign eligible = s_req_tvalid & cfg_port_mask;

  axis_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_pick (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .winner_c   (winner_c),
    .found_c    (found_c)
  );

  // af_q resets high so nothing is granted before almost_full has been sampled once.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IDX_WIDTH'(NUM_PORTS - 1);
      pkt_done_q   <= 1'b0;
      af_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      pkt_done_q   <= pkt_done_d;
      af_q         <= fifo_almost_full;
    end
  end

  // Grant in IDLE, release on the accepted tlast beat.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    pkt_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_enable && !af_q && found_c) begin
          state_d      = BUSY;
          grant_idx_d  = winner_c;
          last_grant_d = winner_c;
        end
      end
      BUSY: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state_d    = IDLE;
          pkt_done_d = 1'b1;
        end
      end
    endcase
  end

  // Zero-latency passthrough of the granted port while BUSY.
  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      req_data[i] = s_req_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      req_strb[i] = s_req_tstrb[i*STRB_WIDTH +: STRB_WIDTH];
    end
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_req_tready  = '0;
    if (state_q == BUSY) begin
      m_axis_tdata              = req_data[grant_idx_q];
      m_axis_tstrb              = req_strb[grant_idx_q];
      m_axis_tlast              = s_req_tlast[grant_idx_q];
      m_axis_tvalid             = s_req_tvalid[grant_idx_q];
      s_req_tready[grant_idx_q] = m_axis_tready;
    end
  end

  assign grant_active = (state_q == BUSY);
  assign grant_idx    = grant_idx_q;
  assign pkt_done     = pkt_done_q;

endmodule

// File: tb/tb_axis_fifo_wr_arbiter.sv
// Directed bench for axis_fifo_wr_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_axis_fifo_wr_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic [127:0] req_tdata;
  logic [15:0]  req_tstrb;
  logic [3:0]   req_tlast, req_tvalid, req_tready;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tstrb;
  logic         m_tlast, m_tvalid, m_tready;
  logic         af, en;
  logic [3:0]   mask;
  logic         active, done;
  logic [1:0]   gidx;

  int checks = 0;
  int errors = 0;
  int cnt [4];
  int len [4];

  always #5 clk = ~clk;

  axis_fifo_wr_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32)) dut (
    .s_axis_aclk      (clk),
    .s_axis_aresetn   (rstn),
    .s_req_tdata      (req_tdata),
    .s_req_tstrb      (req_tstrb),
    .s_req_tlast      (req_tlast),
    .s_req_tvalid     (req_tvalid),
    .s_req_tready     (req_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tstrb     (m_tstrb),
    .m_axis_tlast     (m_tlast),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready),
    .fifo_almost_full (af),
    .cfg_enable       (en),
    .cfg_port_mask    (mask),
    .grant_active     (active),
    .grant_idx        (gidx),
    .pkt_done         (done)
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic [3:0] mask;
    logic       en;
    logic       af;
    logic       act;
    logic [1:0] idx;
    logic       mv;
    logic [3:0] rdy;
    logic       done;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t row(input logic [3:0] mk, input logic e, input logic a,
                               input logic act_e, input logic [1:0] idx_e, input logic mv_e,
                               input logic [3:0] rdy_e, input logic done_e);
    vec_t r;
    r.valid = 4'hf; r.last = 4'hf; r.mask = mk; r.en = e; r.af = a;
    r.act = act_e; r.idx = idx_e; r.mv = mv_e; r.rdy = rdy_e; r.done = done_e;
    return r;
  endfunction

  function automatic logic [31:0] mkd(input int p, input int b);
    return 32'(32'h0A00_0000 + p * 65536 + b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic next_win();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    req_tdata = '0; req_tstrb = '0; req_tlast = '0; req_tvalid = '0;
    m_tready = 1'b1; af = 1'b0; en = 1'b1; mask = 4'hf;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      len[i] = 0;
    end
  endtask

  // Leaves the bench in window 0: reset released, first clock edge not yet seen.
  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    next_win();
    rstn = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_tvalid[i]          = (cnt[i] < len[i]);
      req_tlast[i]           = (cnt[i] == len[i] - 1);
      req_tdata[i*32 +: 32]  = mkd(i, cnt[i]);
      req_tstrb[i*4 +: 4]    = 4'(i + 1);
    end
  endtask

  task automatic hs();
    for (int i = 0; i < 4; i++)
      if (req_tvalid[i] && req_tready[i]) cnt[i]++;
  endtask

  initial begin
    int j;
    int dones;
    int expb [8];

    rstn = 1'b0;
    clear_inputs();
    #3;
    chk("rst_active", 32'(active), 0);
    chk("rst_idx", 32'(gidx), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mvalid", 32'(m_tvalid), 0);
    chk("rst_ready", 32'(req_tready), 0);
    chk("rst_tdata", m_tdata, 0);

    // Single-beat packets from all ports: rotation, mask, almost_full and enable gating.
    tbl[0]  = row(4'hf, 1, 0, 0, 0, 0, 4'h0, 0);
    tbl[1]  = row(4'hf, 1, 0, 0, 0, 0, 4'h0, 0);
    tbl[2]  = row(4'hf, 1, 0, 1, 0, 1, 4'h1, 0);
    tbl[3]  = row(4'hf, 1, 0, 0, 0, 0, 4'h0, 1);
    tbl[4]  = row(4'hf, 1, 0, 1, 1, 1, 4'h2, 0);
    tbl[5]  = row(4'hf, 1, 0, 0, 1, 0, 4'h0, 1);
    tbl[6]  = row(4'hf, 1, 0, 1, 2, 1, 4'h4, 0);
    tbl[7]  = row(4'hf, 1, 0, 0, 2, 0, 4'h0, 1);
    tbl[8]  = row(4'hf, 1, 0, 1, 3, 1, 4'h8, 0);
    tbl[9]  = row(4'ha, 1, 0, 0, 3, 0, 4'h0, 1);
    tbl[10] = row(4'ha, 1, 0, 1, 1, 1, 4'h2, 0);
    tbl[11] = row(4'ha, 1, 0, 0, 1, 0, 4'h0, 1);
    tbl[12] = row(4'ha, 1, 0, 1, 3, 1, 4'h8, 0);
    tbl[13] = row(4'ha, 1, 0, 0, 3, 0, 4'h0, 1);
    tbl[14] = row(4'ha, 1, 1, 1, 1, 1, 4'h2, 0);
    tbl[15] = row(4'ha, 1, 1, 0, 1, 0, 4'h0, 1);
    tbl[16] = row(4'ha, 1, 1, 0, 1, 0, 4'h0, 0);
    tbl[17] = row(4'ha, 1, 0, 0, 1, 0, 4'h0, 0);
    tbl[18] = row(4'ha, 1, 0, 0, 1, 0, 4'h0, 0);
    tbl[19] = row(4'ha, 0, 0, 1, 3, 1, 4'h8, 0);
    tbl[20] = row(4'ha, 0, 0, 0, 3, 0, 4'h0, 1);
    tbl[21] = row(4'ha, 1, 0, 0, 3, 0, 4'h0, 0);
    tbl[22] = row(4'ha, 1, 0, 1, 1, 1, 4'h2, 0);

    do_reset();
    for (int k = 0; k < 23; k++) begin
      req_tvalid = tbl[k].valid;
      req_tlast  = tbl[k].last;
      mask       = tbl[k].mask;
      en         = tbl[k].en;
      af         = tbl[k].af;
      for (int i = 0; i < 4; i++) begin
        req_tdata[i*32 +: 32] = mkd(i, 0);
        req_tstrb[i*4 +: 4]   = 4'(i + 1);
      end
      #1;
      chk($sformatf("T%0d_active", k), 32'(active), 32'(tbl[k].act));
      chk($sformatf("T%0d_idx", k), 32'(gidx), 32'(tbl[k].idx));
      chk($sformatf("T%0d_mvalid", k), 32'(m_tvalid), 32'(tbl[k].mv));
      chk($sformatf("T%0d_ready", k), 32'(req_tready), 32'(tbl[k].rdy));
      chk($sformatf("T%0d_done", k), 32'(done), 32'(tbl[k].done));
      chk($sformatf("T%0d_tdata", k), m_tdata, tbl[k].mv ? mkd(int'(tbl[k].idx), 0) : 32'h0);
      chk($sformatf("T%0d_tstrb", k), 32'(m_tstrb), tbl[k].mv ? 32'(tbl[k].idx) + 1 : 32'h0);
      next_win();
    end

    // A: four simultaneous 3-beat packets, contiguous beats with one IDLE cycle between.
    do_reset();
    for (int i = 0; i < 4; i++) len[i] = 3;
    j = 0;
    dones = 0;
    for (int w = 0; w < 20; w++) begin
      drive();
      #1;
      if (done) dones++;
      if (m_tvalid && m_tready) begin
        chk("A_beat_data", m_tdata, mkd(j / 3, j % 3));
        chk("A_beat_time", 32'(w), 32'(2 + 4 * (j / 3) + (j % 3)));
        j++;
      end
      hs();
      next_win();
    end
    chk("A_beats", 32'(j), 12);
    chk("A_dones", 32'(dones), 4);

    // B: lone single-beat packet on port 2.
    do_reset();
    req_tvalid = 4'b0100;
    req_tlast  = 4'b0100;
    req_tdata[64 +: 32] = 32'hA5A5_A5A5;
    next_win();
    #1;
    chk("B_no_grant_w1", 32'(active), 0);
    next_win();
    #1;
    chk("B_active", 32'(active), 1);
    chk("B_idx", 32'(gidx), 2);
    chk("B_tdata", m_tdata, 32'hA5A5_A5A5);
    chk("B_tlast", 32'(m_tlast), 1);
    chk("B_ready", 32'(req_tready), 32'h4);
    next_win();
    #1;
    chk("B_idle", 32'(active), 0);
    chk("B_done", 32'(done), 1);
    req_tvalid = '0;
    next_win();
    #1;
    chk("B_done_pulse", 32'(done), 0);

    // C: almost_full rises during port 0's 5-beat packet; port 1 waits for af_q to clear.
    do_reset();
    len[0] = 5;
    len[1] = 2;
    for (int w = 0; w < 15; w++) begin
      if (w == 3)  af = 1'b1;
      if (w == 12) af = 1'b0;
      drive();
      #1;
      if (w >= 2 && w <= 6) begin
        chk("C_mvalid", 32'(m_tvalid), 1);
        chk("C_idx", 32'(gidx), 0);
        chk("C_tdata", m_tdata, mkd(0, w - 2));
      end
      if (w >= 7 && w <= 13) chk("C_hold", 32'(active), 0);
      if (w == 7)  chk("C_done", 32'(done), 1);
      if (w == 14) begin
        chk("C_regrant", 32'(active), 1);
        chk("C_regrant_idx", 32'(gidx), 1);
      end
      hs();
      next_win();
    end
    chk("C_beats", 32'(cnt[0]), 5);

    // D: tready pattern 1,0,0,1 during port 3's 4-beat packet.
    do_reset();
    len[3] = 4;
    expb = '{0, 0, 0, 1, 1, 1, 2, 3};
    for (int w = 0; w < 10; w++) begin
      if (w == 2) len[1] = 3;
      m_tready = (w == 3 || w == 4) ? 1'b0 : 1'b1;
      drive();
      #1;
      if (w >= 2 && w <= 7) begin
        chk("D_mvalid", 32'(m_tvalid), 1);
        chk("D_tdata", m_tdata, mkd(3, expb[w]));
        chk("D_tlast", 32'(m_tlast), 32'(expb[w] == 3));
        chk("D_ready", 32'(req_tready), {28'h0, m_tready, 3'b000});
      end
      if (w == 8) begin
        chk("D_done", 32'(done), 1);
        chk("D_idle", 32'(active), 0);
      end
      if (w == 9) chk("D_next_idx", {31'h0, active, gidx} , 32'b101);
      hs();
      next_win();
    end

    // E: masked alternation, then reset in the middle of port 1's packet.
    do_reset();
    mask = 4'b1010;
    for (int i = 0; i < 4; i++) len[i] = 4;
    for (int w = 0; w < 4; w++) begin
      drive();
      #1;
      if (w >= 2) chk("E_idx1", {31'h0, active, gidx}, 32'b101);
      hs();
      if (w < 3) next_win();
    end
    rstn = 1'b0;
    #1;
    chk("E_rst_ready", 32'(req_tready), 0);
    chk("E_rst_active", 32'(active), 0);
    chk("E_rst_mvalid", 32'(m_tvalid), 0);
    do_reset();
    for (int i = 0; i < 4; i++) len[i] = 4;
    for (int w = 0; w < 3; w++) begin
      drive();
      #1;
      if (w == 2) chk("E_first_after_rst", {31'h0, active, gidx}, 32'b100);
      hs();
      next_win();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
